// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path and its timer helpers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } sw_state_e;

    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int SUB_W   = 7;
    localparam int SUB_MAX = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [SUB_W-1:0] sub;
    } sw_time_t;

    function automatic logic is_counting(sw_state_e s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// Prescaler producing a registered one-clock tick every TICK_DIV enabled clocks.
module sw_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic hold,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] pre_cnt;

    // Hold keeps the partial count so a pause does not lose the fraction of a tick.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (en && !hold) begin
            tick    <= (pre_cnt == LAST);
            pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
        end else begin
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button sequencer for the stopwatch: run/pause/clear/lap FSM, tick gating,
// lap snapshot and the display mux between counter and display.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int LAP_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_ss,
    input  logic             btn_lr,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [SEC_W-1:0] cur_sec,
    input  logic [SUB_W-1:0] cur_subsec,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             running,
    output logic             frozen,
    output logic [MIN_W-1:0] disp_min,
    output logic [SEC_W-1:0] disp_sec,
    output logic [SUB_W-1:0] disp_subsec,
    output logic [LAP_W-1:0] lap_cnt
);

    sw_state_e state;
    sw_time_t  lap_t;
    logic      ss_q, lr_q;
    logic      ss_ev, lr_ev;

    // Start/stop wins a simultaneous press; the lap/reset press is dropped.
    assign ss_ev = btn_ss & ~ss_q;
    assign lr_ev = btn_lr & ~lr_q & ~ss_ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ss_q    <= 1'b0;
            lr_q    <= 1'b0;
            lap_t   <= '0;
            lap_cnt <= '0;
        end else begin
            ss_q <= btn_ss;
            lr_q <= btn_lr;
            case (state)
                IDLE: begin
                    lap_t   <= '0;
                    lap_cnt <= '0;
                    if (ss_ev) state <= RUN;
                end
                RUN: begin
                    if (ss_ev) begin
                        state <= STOP;
                    end else if (lr_ev) begin
                        state <= LAP;
                        lap_t <= '{min: cur_min, sec: cur_sec, sub: cur_subsec};
                        if (lap_cnt != {LAP_W{1'b1}}) lap_cnt <= lap_cnt + 1'b1;
                    end
                end
                LAP: begin
                    if (ss_ev)      state <= STOP;
                    else if (lr_ev) state <= RUN;
                end
                STOP: begin
                    if (ss_ev) begin
                        state <= RUN;
                    end else if (lr_ev) begin
                        state   <= IDLE;
                        lap_t   <= '0;
                        lap_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cnt_clr = (state == IDLE);
    assign running = is_counting(state);
    assign frozen  = (state == LAP);

    assign disp_min    = frozen ? lap_t.min : cur_min;
    assign disp_sec    = frozen ? lap_t.sec : cur_sec;
    assign disp_subsec = frozen ? lap_t.sub : cur_subsec;

    // Within RUN/LAP only start/stop leaves the counting states, so it alone kills a pending tick.
    sw_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (is_counting(state) && !ss_ev),
        .hold  (state == STOP),
        .clr   (state == IDLE),
        .tick  (cnt_en)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed and random stimulus for stopwatch_ctrl, checked against a cycle-level behavioural model.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 10;
    localparam int LAP_W    = 4;
    localparam int LAP_SAT  = (1 << LAP_W) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_ss = 1'b0, btn_lr = 1'b0;
    logic [5:0] cur_min = '0, cur_sec = '0;
    logic [6:0] cur_subsec = '0;
    logic cnt_en, cnt_clr, running, frozen;
    logic [5:0] disp_min, disp_sec;
    logic [6:0] disp_subsec;
    logic [LAP_W-1:0] lap_cnt;

    int passed = 0, total = 0, fails = 0;

    // behavioural model state
    int m_mode = M_IDLE;
    int m_ss_q = 0, m_lr_q = 0;
    int m_elapsed = 0, m_tick = 0, m_laps = 0;
    int m_lap_min = 0, m_lap_sec = 0, m_lap_sub = 0;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .LAP_W(LAP_W)) dut (
        .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .cur_min(cur_min), .cur_sec(cur_sec), .cur_subsec(cur_subsec),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .running(running), .frozen(frozen),
        .disp_min(disp_min), .disp_sec(disp_sec), .disp_subsec(disp_subsec),
        .lap_cnt(lap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit counts(input int m);
        return (m == M_RUN) || (m == M_LAP);
    endfunction

    task automatic model_edge();
        bit ss, lr, cnt;
        int nm;
        if (reset) begin
            m_mode = M_IDLE; m_ss_q = 0; m_lr_q = 0;
            m_elapsed = 0; m_tick = 0; m_laps = 0;
            m_lap_min = 0; m_lap_sec = 0; m_lap_sub = 0;
        end else begin
            ss = btn_ss && (m_ss_q == 0);
            lr = btn_lr && (m_lr_q == 0) && !ss;
            nm = m_mode;
            case (m_mode)
                M_IDLE: if (ss) nm = M_RUN;
                M_RUN:  if (ss) nm = M_STOP; else if (lr) nm = M_LAP;
                M_LAP:  if (ss) nm = M_STOP; else if (lr) nm = M_RUN;
                default: if (ss) nm = M_RUN; else if (lr) nm = M_IDLE;
            endcase
            cnt = counts(m_mode) && counts(nm);
            m_tick = (cnt && m_elapsed == TICK_DIV - 1) ? 1 : 0;
            if (m_mode == M_IDLE) m_elapsed = 0;
            else if (cnt) m_elapsed = (m_elapsed + 1) % TICK_DIV;
            if (m_mode == M_IDLE || nm == M_IDLE) begin
                m_laps = 0; m_lap_min = 0; m_lap_sec = 0; m_lap_sub = 0;
            end else if (m_mode == M_RUN && nm == M_LAP) begin
                m_lap_min = cur_min; m_lap_sec = cur_sec; m_lap_sub = cur_subsec;
                if (m_laps < LAP_SAT) m_laps = m_laps + 1;
            end
            m_mode = nm; m_ss_q = btn_ss; m_lr_q = btn_lr;
        end
    endtask

    task automatic check_all();
        bit fz;
        fz = (m_mode == M_LAP);
        chk("cnt_en", cnt_en, m_tick);
        chk("cnt_clr", cnt_clr, m_mode == M_IDLE);
        chk("running", running, counts(m_mode));
        chk("frozen", frozen, fz);
        chk("lap_cnt", lap_cnt, m_laps);
        chk("disp_min", disp_min, fz ? m_lap_min : int'(cur_min));
        chk("disp_sec", disp_sec, fz ? m_lap_sec : int'(cur_sec));
        chk("disp_subsec", disp_subsec, fz ? m_lap_sub : int'(cur_subsec));
    endtask

    task automatic step(input logic s, input logic l, input logic r);
        @(negedge clk);
        btn_ss = s; btn_lr = l; reset = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int g;
        // 1: reset, start, ticks every TICK_DIV clocks
        step(0, 0, 1);
        step(0, 0, 1);
        chk("rst_clr", cnt_clr, 1);
        chk("rst_run", running, 0);
        step(1, 0, 0);
        chk("t1_run", running, 1);
        chk("t1_clr", cnt_clr, 0);
        for (int k = 1; k <= 30; k++) begin
            step(0, 0, 0);
            chk("t1_tick", cnt_en, (k % TICK_DIV) == 0);
        end

        // 2: lap freezes display, second lap releases it
        cur_min = 6'd1; cur_sec = 6'd2; cur_subsec = 7'd37;
        step(0, 1, 0);
        chk("t2_frozen", frozen, 1);
        chk("t2_lapcnt", lap_cnt, 1);
        for (int v = 38; v <= 45; v++) begin
            cur_subsec = 7'(v);
            step(0, 0, 0);
            chk("t2_hold_sub", disp_subsec, 37);
            chk("t2_hold_sec", disp_sec, 2);
        end
        cur_subsec = 7'd46;
        step(0, 1, 0);
        chk("t2_unfrozen", frozen, 0);
        chk("t2_live", disp_subsec, 46);

        // 3: pause preserves the partial tick
        g = 0;
        while (m_elapsed != 6 && g < 3 * TICK_DIV) begin
            step(0, 0, 0);
            g++;
        end
        chk("t3_align", m_elapsed, 6);
        step(1, 0, 0);
        chk("t3_stop", running, 0);
        for (int k = 1; k <= 50; k++) begin
            step(0, 0, 0);
            chk("t3_no_tick", cnt_en, 0);
        end
        step(1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0);
            chk("t3_resume", cnt_en, k == 4);
        end

        // 4: clear from STOP, lap/reset ignored in IDLE
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        chk("t4_clr", cnt_clr, 1);
        chk("t4_lapcnt", lap_cnt, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        chk("t4_idle", running, 0);
        chk("t4_idle_clr", cnt_clr, 1);

        // 5: simultaneous press, then lap saturation
        step(1, 0, 0); step(0, 0, 0);
        step(0, 1, 0); step(0, 0, 0);
        step(0, 1, 0); step(0, 0, 0);
        step(1, 1, 0);
        chk("t5_stop", running, 0);
        chk("t5_nofreeze", frozen, 0);
        chk("t5_lapcnt", lap_cnt, 1);
        step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
        for (int p = 0; p < 17; p++) begin
            step(0, 1, 0); step(0, 0, 0);
            step(0, 1, 0); step(0, 0, 0);
        end
        chk("t5_sat", lap_cnt, 15);

        // 6: reset in LAP on the tick cycle, start held through reset
        step(0, 1, 0);
        g = 0;
        while (m_elapsed != TICK_DIV - 1 && g < 3 * TICK_DIV) begin
            step(0, 0, 0);
            g++;
        end
        chk("t6_align", m_elapsed, TICK_DIV - 1);
        step(1, 0, 1);
        chk("t6_cnt_en", cnt_en, 0);
        chk("t6_frozen", frozen, 0);
        chk("t6_clr", cnt_clr, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        chk("t6_run", running, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t6_one_event", running, 1);
        step(0, 0, 0);

        // random soak against the model
        for (int k = 0; k < 600; k++) begin
            cur_min = 6'($urandom_range(0, 63));
            cur_sec = 6'($urandom_range(0, 63));
            cur_subsec = 7'($urandom_range(0, 127));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 79) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the min/sec/subsec stopwatch counter datapath. Converts two level-sensitive, already-debounced buttons into run, pause, clear and lap actions. Generates the gated 1/100 s count-enable tick from the system clock. Owns the lap snapshot and the display mux that sits between the counter and the display.

Parameters:
TICK_DIV, 10, system clocks per 1/100 s tick (10 at 1 kHz clk); legal range >= 2
LAP_W, 4, width of the saturating lap counter

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high; sampled on posedge clk
btn_ss  input  1  start/stop button level; rising edge = action
btn_lr  input  1  lap/reset button level; rising edge = action
cur_min  input  6  live minutes from counter (0..59)
cur_sec  input  6  live seconds from counter (0..59)
cur_subsec  input  7  live hundredths from counter (0..99)
cnt_en  output  1  one-clock count-enable pulse to counter
cnt_clr  output  1  level clear to counter
running  output  1  high in RUN or LAP
frozen  output  1  high in LAP (display held)
disp_min  output  6  displayed minutes
disp_sec  output  6  displayed seconds
disp_subsec  output  7  displayed hundredths
lap_cnt  output  LAP_W  laps taken since last clear, saturating

Behaviour:
- Edge detect: ss_q and lr_q register the button levels. ss_ev = btn_ss & ~ss_q; lr_ev = btn_lr & ~lr_q. Both registers are 0 after reset, so a button held through reset produces an event on the first cycle after reset.
- An event is acted on at the same posedge where the new level is first sampled high. Holding a button produces exactly one event.
- If ss_ev and lr_ev occur in the same cycle, ss_ev is taken and lr_ev is discarded.
- FSM states: IDLE, RUN, LAP, STOP. Reset forces IDLE.
- IDLE: ss_ev goes to RUN. lr_ev is ignored.
- RUN: ss_ev goes to STOP. lr_ev goes to LAP, captures cur_* into the lap registers and increments lap_cnt.
- LAP: ss_ev goes to STOP (display returns live). lr_ev goes to RUN (display returns live; no capture, no increment).
- STOP: ss_ev goes to RUN. lr_ev goes to IDLE.
- Prescaler: pre_cnt counts 0..TICK_DIV-1 and wraps.
  - Counts only in RUN and LAP.
  - Holds its value in STOP, so the partial tick is preserved across a pause.
  - Forced to 0 in IDLE and on reset.
- cnt_en is registered: 1 for the single cycle after the cycle in which pre_cnt == TICK_DIV-1 while counting.
  - The first tick comes TICK_DIV clocks after entering RUN from IDLE.
  - Leaving RUN/LAP suppresses any pending tick.
- cnt_clr = (state == IDLE), decoded from the state register. It is 1 during reset and after reset.
- running = RUN|LAP; frozen = LAP. Both are decoded from state.
- Display mux:
  - disp_* = lap registers when frozen.
  - Otherwise disp_* = cur_* (combinational passthrough, zero latency).
- Lap registers:
  - Cleared to 0 on reset and in IDLE.
  - Written only on the RUN to LAP transition.
- lap_cnt:
  - 0 on reset and in IDLE.
  - +1 on each RUN to LAP transition.
  - Saturates at 2^LAP_W-1.
- Reset values: state IDLE; cnt_en 0; cnt_clr 1; running 0; frozen 0; lap_cnt 0; lap registers 0; disp_* = cur_*.
- A synchronous reset takes priority over any event in the same cycle, including mid-LAP or mid-tick.
- No range checking of cur_*; values are passed through as-is.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, LAP=2'd2, STOP=2'd3;
  - field widths: MIN_W=6, SEC_W=6, SUB_W=7;
  - limits: SUB_MAX=99, SEC_MAX=59, MIN_MAX=59.
- One natural sub-module, sw_tick_gen: prescaler with enable, hold and clear inputs and a registered tick output. It is reused by any later timer blocks.
- Edge detect, FSM, lap registers and display mux stay in stopwatch_ctrl.

Test Plan:
1. Reset, then ss pulse at t0 with TICK_DIV=10:
   - running=1 from t0+1;
   - cnt_en pulses at t0+10, t0+20, t0+30;
   - cnt_clr drops to 0 at t0+1.
2. RUN with cur=01:02:37, then lr pulse:
   - frozen=1, disp=01:02:37 held while cur advances to 01:02:45;
   - lap_cnt=1;
   - a second lr pulse gives frozen=0 and disp tracks cur on the same cycle.
3. RUN with pre_cnt=6, ss pulse (STOP) for 50 clocks, then ss pulse (RUN):
   - no cnt_en while stopped;
   - next cnt_en exactly 4 clocks after resume.
4. In STOP, lr pulse:
   - state IDLE, cnt_clr=1, lap_cnt=0, lap registers 0;
   - a following lr pulse in IDLE changes nothing.
5. In RUN, btn_ss and btn_lr rise in the same cycle:
   - goes to STOP, no lap capture, lap_cnt unchanged.
   - With LAP_W=4, 17 lap/unlap pairs leave lap_cnt at 15.
6. reset asserted in LAP during the cycle pre_cnt=TICK_DIV-1:
   - next cycle IDLE, cnt_en=0, frozen=0, cnt_clr=1.
   - btn_ss held high through reset gives exactly one event, entering RUN on the first cycle after reset.
